// File: rtl/array_rw_ctrl_pkg.sv
// array_rw_ctrl_pkg: shared types and default widths for the RW0 array controller.
package array_rw_ctrl_pkg;

    localparam int ADDR_W_DEF = 7;
    localparam int DATA_W_DEF = 36;

    typedef enum logic {ST_INIT, ST_RUN} state_e;

    typedef struct packed {
        logic                  en;
        logic                  wmode;
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] wmask;
        logic [DATA_W_DEF-1:0] wdata;
    } rw0_cmd_t;

endpackage

// File: rtl/array_resp_fifo.sv
// array_resp_fifo: small synchronous FIFO with registered storage and occupancy output.
module array_resp_fifo #(
    parameter int DEPTH = 3,
    parameter int W     = 36,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  pop_data,
    output logic          valid,
    output logic [CW-1:0] count
);
    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        wr_d  = push ? (wr_q == PW'(DEPTH - 1) ? '0 : wr_q + PW'(1)) : wr_q;
        rd_d  = pop ? (rd_q == PW'(DEPTH - 1) ? '0 : rd_q + PW'(1)) : rd_q;
        cnt_d = cnt_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) mem_q[wr_q] <= push_data;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    assign pop_data = mem_q[rd_q];
    assign valid    = cnt_q != '0;
    assign count    = cnt_q;

endmodule

// File: rtl/array_rw_ctrl.sv
// array_rw_ctrl: arbitrates write and read request streams onto the single RW0 port,
// sweeps the array after reset and returns read data through a credited response FIFO.
module array_rw_ctrl
    import array_rw_ctrl_pkg::*;
#(
    parameter int              ADDR_W        = ADDR_W_DEF,
    parameter int              DATA_W        = DATA_W_DEF,
    parameter int              RESP_DEPTH    = 3,
    parameter bit              INIT_ON_RESET = 1'b1,
    parameter logic [DATA_W-1:0] INIT_VALUE  = '0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              w_valid,
    output logic              w_ready,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [DATA_W-1:0] w_data,
    input  logic [DATA_W-1:0] w_mask,
    input  logic              r_req_valid,
    output logic              r_req_ready,
    input  logic [ADDR_W-1:0] r_req_addr,
    output logic              r_resp_valid,
    input  logic              r_resp_ready,
    output logic [DATA_W-1:0] r_resp_data,
    output logic              init_done,
    output logic [ADDR_W-1:0] RW0_addr,
    output logic              RW0_en,
    output logic              RW0_wmode,
    output logic [DATA_W-1:0] RW0_wmask,
    output logic [DATA_W-1:0] RW0_wdata,
    input  logic [DATA_W-1:0] RW0_rdata
);
    localparam int CW = $clog2(RESP_DEPTH + 1);

    state_e            state_q, state_d;
    logic              alive_q, done_q, done_d, last_rd_q, last_rd_d, inflight_q;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [CW-1:0]     occ;
    logic              init_wr, rd_elig, rv, w_gnt, r_gnt;
    rw0_cmd_t          cmd;

    // alive_q holds the array idle until the first edge after reset release
    assign init_wr     = state_q == ST_INIT && alive_q;
    assign rd_elig     = done_q && ({1'b0, occ} + (CW+1)'(inflight_q) < (CW+1)'(RESP_DEPTH));
    assign rv          = r_req_valid && rd_elig;
    assign w_ready     = done_q && (!rv || last_rd_q);
    assign r_req_ready = rd_elig && (!w_valid || !last_rd_q);
    assign w_gnt       = w_valid && w_ready;
    assign r_gnt       = r_req_valid && r_req_ready;
    assign init_done   = done_q;

    always_comb begin
        cmd       = '0;
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_rd_d = (rv && w_valid) ? r_gnt : last_rd_q;
        if (init_wr) begin
            cmd     = '{en: 1'b1, wmode: 1'b1, addr: cnt_q, wmask: '1, wdata: INIT_VALUE};
            cnt_d   = cnt_q + ADDR_W'(1);
            state_d = &cnt_q ? ST_RUN : ST_INIT;
        end else if (w_gnt) begin
            cmd = '{en: 1'b1, wmode: 1'b1, addr: w_addr, wmask: w_mask, wdata: w_data};
        end else if (r_gnt) begin
            cmd = '{en: 1'b1, wmode: 1'b0, addr: r_req_addr, wmask: '0, wdata: '0};
        end
        done_d = state_d == ST_RUN;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= INIT_ON_RESET ? ST_INIT : ST_RUN;
            alive_q    <= 1'b0;
            done_q     <= 1'b0;
            last_rd_q  <= 1'b0;
            inflight_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            alive_q    <= 1'b1;
            done_q     <= done_d;
            last_rd_q  <= last_rd_d;
            inflight_q <= r_gnt;
            cnt_q      <= cnt_d;
        end
    end

    assign RW0_en    = cmd.en;
    assign RW0_wmode = cmd.wmode;
    assign RW0_addr  = cmd.addr;
    assign RW0_wmask = cmd.wmask;
    assign RW0_wdata = cmd.wdata;

    // read data is only valid the cycle after a read grant, so inflight_q is the push
    array_resp_fifo #(.DEPTH(RESP_DEPTH), .W(DATA_W)) u_resp_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (inflight_q),
        .push_data (RW0_rdata),
        .pop       (r_resp_valid && r_resp_ready),
        .pop_data  (r_resp_data),
        .valid     (r_resp_valid),
        .count     (occ)
    );

endmodule

// File: tb/tb_array_rw_ctrl.sv
// tb_array_rw_ctrl: directed checks of init sweep, read/write, arbitration, backpressure and reset.
module tb_array_rw_ctrl;
    logic        clock = 1'b0, reset_n = 1'b0;
    logic        w_valid = 0, w_ready, r_req_valid = 0, r_req_ready;
    logic [6:0]  w_addr = 0, r_req_addr = 0, RW0_addr;
    logic [35:0] w_data = 0, w_mask = 0, r_resp_data, RW0_wmask, RW0_wdata;
    logic [35:0] RW0_rdata = 36'hB_ADBA_DBAD;
    logic        r_resp_valid, r_resp_ready = 0, init_done, RW0_en, RW0_wmode;
    logic [35:0] mem [128];
    int          n_chk = 0, n_fail = 0;

    array_rw_ctrl dut (
        .clock(clock), .reset_n(reset_n),
        .w_valid(w_valid), .w_ready(w_ready), .w_addr(w_addr), .w_data(w_data), .w_mask(w_mask),
        .r_req_valid(r_req_valid), .r_req_ready(r_req_ready), .r_req_addr(r_req_addr),
        .r_resp_valid(r_resp_valid), .r_resp_ready(r_resp_ready), .r_resp_data(r_resp_data),
        .init_done(init_done), .RW0_addr(RW0_addr), .RW0_en(RW0_en), .RW0_wmode(RW0_wmode),
        .RW0_wmask(RW0_wmask), .RW0_wdata(RW0_wdata), .RW0_rdata(RW0_rdata)
    );

    always #5 clock = ~clock;

    // array macro model: masked write, 1-cycle read, junk on non-read cycles
    always @(posedge clock) begin
        if (RW0_en && RW0_wmode) mem[RW0_addr] <= (mem[RW0_addr] & ~RW0_wmask) | (RW0_wdata & RW0_wmask);
        RW0_rdata <= (RW0_en && !RW0_wmode) ? mem[RW0_addr] : 36'hB_ADBA_DBAD;
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [6:0] a, input logic [35:0] d, input logic [35:0] m);
        @(negedge clock);
        w_valid = 1; r_req_valid = 0; w_addr = a; w_data = d; w_mask = m;
        #1 chk("wr_cmd", {w_ready, RW0_en, RW0_wmode, RW0_addr, RW0_wmask, RW0_wdata}, {3'b111, a, m, d});
    endtask

    task automatic rd(input logic [6:0] a, input logic [35:0] exp);
        @(negedge clock);
        w_valid = 0; r_req_valid = 1; r_req_addr = a; r_resp_ready = 1;
        #1 chk("rd_cmd", {r_req_ready, RW0_en, RW0_wmode, RW0_addr}, {3'b110, a});
        @(negedge clock);
        r_req_valid = 0;
        #1 chk("rd_n1", r_resp_valid, 0);
        @(negedge clock);
        #1 chk("rd_n2", {r_resp_valid, r_resp_data}, {1'b1, exp});
    endtask

    int acc;
    logic [35:0] bp_val [3] = '{36'h1_1111_1111, 36'h2_2222_2222, 36'h3_3333_3333};

    initial begin
        #1 chk("reset_vals", {w_ready, r_req_ready, r_resp_valid, r_resp_data, init_done,
                              RW0_en, RW0_wmode, RW0_addr, RW0_wmask, RW0_wdata}, '0);
        @(negedge clock);
        reset_n = 1; w_valid = 1; r_req_valid = 1; w_addr = 7'd3; r_req_addr = 7'd4; w_mask = '1;
        for (int i = 0; i < 128; i++) begin
            @(negedge clock);
            #1 chk("init_sweep", {RW0_en, RW0_wmode, RW0_addr, RW0_wmask, RW0_wdata, w_ready, r_req_ready, init_done},
                   {2'b11, 7'(i), {36{1'b1}}, 36'h0, 3'b000});
            if (i == 127) begin w_valid = 0; r_req_valid = 0; end
        end
        @(negedge clock);
        #1 chk("init_done", {init_done, RW0_en, w_ready, r_req_ready}, 4'b1011);
        wr(7'd5, 36'h9_1234_5678, '1);
        rd(7'd5, 36'h9_1234_5678);
        wr(7'd9, '1, '1);
        wr(7'd9, 36'h0, 36'h0_0000_FFFF);
        rd(7'd9, 36'hF_FFFF_0000);
        @(negedge clock);
        w_valid = 1; r_req_valid = 1; w_addr = 7'd20; w_data = 36'h7; w_mask = '1; r_req_addr = 7'd9;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clock);
            #1 chk("contend", {RW0_en, RW0_wmode, w_ready, r_req_ready}, {1'b1, i[0], i[0], ~i[0]});
        end
        @(negedge clock);
        w_valid = 0; r_req_valid = 0;
        repeat (4) @(negedge clock);
        for (int i = 0; i < 3; i++) wr(7'(30 + i), bp_val[i], '1);
        acc = 0;
        r_resp_ready = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            w_valid = 0; r_req_valid = 1; r_req_addr = 7'(30 + acc);
            #1 chk("bp_ready", r_req_ready, i < 3);
            if (r_req_ready) acc++;
        end
        chk("bp_accepted", acc, 3);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            r_req_valid = 0; r_resp_ready = 1;
            #1 chk("bp_drain", {r_resp_valid, r_resp_data}, {1'b1, bp_val[i]});
        end
        @(negedge clock);
        #1 chk("bp_empty", r_resp_valid, 0);
        @(negedge clock);
        r_req_valid = 1; r_req_addr = 7'd5;
        #1 chk("mid_rd_grant", {r_req_ready, RW0_en, RW0_wmode}, 3'b110);
        @(negedge clock);
        r_req_valid = 0; reset_n = 0;
        #1 chk("mid_rd_reset", {r_resp_valid, RW0_en, init_done, w_ready}, 4'b0000);
        @(negedge clock);
        #1 chk("mid_rd_noresp", {r_resp_valid, RW0_en}, 2'b00);
        reset_n = 1;
        @(negedge clock);
        #1 chk("reinit0", {RW0_en, RW0_wmode, RW0_addr, r_resp_valid, init_done}, {2'b11, 7'd0, 2'b00});
        @(negedge clock);
        #1 chk("reinit1", {RW0_en, RW0_wmode, RW0_addr, r_resp_valid, init_done}, {2'b11, 7'd1, 2'b00});
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/array_rw_ctrl.md
# array_rw_ctrl

Requester-side controller for the single-port 128x36 array macro (RW0 port: shared read/write, 1-cycle registered-address read). It turns two independent valid/ready request streams into legal RW0 commands, one per cycle: a masked-write stream and a read-request stream. Read data is returned on a buffered response stream. After reset it sweeps the array to a known value. It sits between a cache/predictor pipeline and the array macro, whose RW0_clk is tied to `clock` at the parent.

## Interface
Parameters:
- ADDR_W, 7, array address width; DEPTH = 2^ADDR_W.
- DATA_W, 36, word and mask width.
- RESP_DEPTH, 3, response buffer entries (min 2; 3 gives full read throughput).
- INIT_ON_RESET, 1, sweep array after reset when 1.
- INIT_VALUE, 0, word written by the sweep.

Ports:
- clock  in  1  sole clock.
- reset_n  in  1  asynchronous, active-low reset.
- w_valid / w_ready  in/out  1  write request handshake.
- w_addr  in  ADDR_W  write address.
- w_data  in  DATA_W  write data.
- w_mask  in  DATA_W  per-bit write enable.
- r_req_valid / r_req_ready  in/out  1  read request handshake.
- r_req_addr  in  ADDR_W  read address.
- r_resp_valid / r_resp_ready  out/in  1  read response handshake.
- r_resp_data  out  DATA_W  read data.
- init_done  out  1  high once the array is usable.
- RW0_addr  out  ADDR_W  array address.
- RW0_en  out  1  array enable.
- RW0_wmode  out  1  1 = write, 0 = read.
- RW0_wmask  out  DATA_W  array write mask.
- RW0_wdata  out  DATA_W  array write data.
- RW0_rdata  in  DATA_W  array read data; valid only the cycle after a read.

## Operation
- States: INIT and RUN. Reset enters INIT if INIT_ON_RESET, else RUN.
- INIT:
  - One write per cycle: addr = counter, wmask all ones, wdata INIT_VALUE, counter 0..DEPTH-1.
  - w_ready and r_req_ready are low.
  - After the write to DEPTH-1, go to RUN.
- RUN: at most one grant per cycle. RW0 outputs are combinational from the grant.
- Write grant: RW0_en=1, wmode=1, addr/mask/data passed through. An all-zero mask still issues a command (no-op).
- Read grant: RW0_en=1, wmode=0. An inflight flag is set.
- Read data capture:
  - The cycle after a read grant, RW0_rdata is pushed into the response FIFO unconditionally.
  - RW0_rdata is never sampled in any other cycle.
- Read eligibility: (FIFO occupancy + inflight) < RESP_DEPTH. No combinational path from r_resp_ready to r_req_ready.
- Arbitration when both requests are eligible and valid:
  - Alternate between read and write. A last-winner bit is updated only on contended cycles.
  - The bit resets to read-first.
  - Uncontended requests win immediately.
- ready signals: w_ready = RUN and (no eligible read valid, or write's turn). r_req_ready = RUN and eligible and (no w_valid, or read's turn).
- When RW0_en=0, RW0_addr, RW0_wmask, RW0_wdata and RW0_wmode are driven to 0.
- Ordering:
  - A write granted in cycle N is visible to a read granted in N+1 or later.
  - Responses return in request order.
- init_done:
  - 0 during INIT.
  - 1 from the first RUN cycle onward.
  - With INIT_ON_RESET=0: 1 from the first cycle after reset release.

## Timing
- Reset values: w_ready 0, r_req_ready 0, r_resp_valid 0, r_resp_data 0, init_done 0, all RW0_* 0. FIFO is empty, inflight 0, state as above.
- INIT lasts exactly DEPTH cycles from the first clock edge after reset release.
- Read latency: accept in N → RW0_rdata in N+1 → r_resp_valid in N+2 (registered FIFO, no bypass).
- Sustained throughput is one read per cycle with RESP_DEPTH=3 and r_resp_ready held high.
- Full FIFO with r_resp_ready low: r_req_ready drops. The inflight read still lands (credits guarantee space).
- Simultaneous FIFO push and pop: occupancy unchanged. Data order is preserved.
- Reset asserted mid-INIT or mid-read: all state clears asynchronously. The inflight read is discarded. INIT restarts at address 0.

## Structure
- Shared package holds:
  - the state enum (INIT, RUN);
  - the RW0 command struct {en, wmode, addr, wmask, wdata};
  - the ADDR_W/DATA_W defaults.
- One sub-module: array_resp_fifo, a parameterised RESP_DEPTH x DATA_W synchronous FIFO with occupancy output.

## Test plan
- Init sweep: release reset → 128 consecutive RW0 writes at addr 0..127 with mask 0xF_FFFF_FFFF and data 0. init_done rises at cycle 128. Both readies stay low until then.
- Write then read: write addr 5 data 0x9_1234_5678 full mask, then read addr 5 → r_resp_valid two cycles after accept with 0x9_1234_5678.
- Masked write: addr 9 holds 0xF_FFFF_FFFF, write data 0 with mask 0x0_0000_FFFF → read returns 0xF_FFFF_0000.
- Contention: w_valid and r_req_valid held high for 6 cycles → grants alternate R, W, R, W, R, W. RW0_wmode is 0,1,0,1,0,1.
- Backpressure: r_resp_ready low, reads streamed → exactly 3 accepted, then r_req_ready low. Raising r_resp_ready drains all 3 in order with one per cycle.
- Reset mid-read: assert reset_n low the cycle after a read grant → no response emitted. INIT restarts at addr 0 after release.
